// File: rtl/dff_bank_arbiter_if.sv
// dff_bank_arbiter_if: requester/bank bundle shared between requesters and the arbiter
interface dff_bank_arbiter_if #(
  parameter int WIDTH   = 4,
  parameter int N_REQ   = 4,
  parameter int OWNER_W = $clog2(N_REQ)
);
  logic [N_REQ-1:0]       input_req;
  logic [N_REQ*WIDTH-1:0] input_data;
  logic                   input_freeze;
  logic [N_REQ-1:0]       output_grant;
  logic [N_REQ-1:0]       output_ack;
  logic [OWNER_W-1:0]     output_owner;
  logic                   output_busy;
  logic [WIDTH-1:0]       output_q;
  logic [WIDTH-1:0]       output_qn;
  modport master (
    output input_req, input_data, input_freeze,
    input  output_grant, output_ack, output_owner, output_busy, output_q, output_qn
  );
  modport slave (
    input  input_req, input_data, input_freeze,
    output output_grant, output_ack, output_owner, output_busy, output_q, output_qn
  );
endinterface

// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: round-robin writer arbitration onto one shared D flip-flop bank
module dff_bank_arbiter #(
  parameter int WIDTH = 4,
  parameter int N_REQ = 4
) (
  input logic                 input_clock1_1,
  input logic                 input_reset1_2,
  dff_bank_arbiter_if.slave   bus
);
  localparam int OWNER_W = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;
  state_t               state, state_nx;
  logic [OWNER_W-1:0]   owner, ptr;
  logic [WIDTH-1:0]     q;
  logic [OWNER_W:0]     pick;
  logic [WIDTH-1:0]     words [N_REQ];
  for (genvar i = 0; i < N_REQ; i++) begin : g_words
    assign words[i] = bus.input_data[i*WIDTH +: WIDTH];
  end
  // MSB flags a hit; search starts just after ptr so the last winner ranks lowest
  function automatic logic [OWNER_W:0] first_req(input logic [N_REQ-1:0] r, input logic [OWNER_W-1:0] p);
    logic [OWNER_W:0] j;
    first_req = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      j = {1'b0, p} + (OWNER_W+1)'(k);
      j = (j >= (OWNER_W+1)'(N_REQ)) ? j - (OWNER_W+1)'(N_REQ) : j;
      if (r[j[OWNER_W-1:0]]) first_req = {1'b1, j[OWNER_W-1:0]};
    end
  endfunction
  always_comb begin
    pick     = first_req(bus.input_req, ptr);
    state_nx = state == IDLE  ? ((pick[OWNER_W] && !bus.input_freeze) ? GRANT : IDLE)
             : state == GRANT ? ACK : IDLE;
  end
  always_ff @(posedge input_clock1_1) begin
    if (input_reset1_2) begin
      state <= IDLE;
      q     <= '0;
      owner <= '0;
      ptr   <= OWNER_W'(N_REQ - 1);
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx == GRANT) owner <= pick[OWNER_W-1:0];
      if (state == GRANT) q <= words[owner];
      if (state == ACK) ptr <= owner;
    end
  end
  assign bus.output_grant = (state == GRANT) ? N_REQ'(1) << owner : '0;
  assign bus.output_ack   = (state == ACK) ? N_REQ'(1) << owner : '0;
  assign bus.output_busy  = state != IDLE;
  assign bus.output_owner = owner;
  assign bus.output_q     = q;
  assign bus.output_qn    = ~q;
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb_dff_bank_arbiter: directed test-plan scenarios plus random traffic against a transaction-level model
module tb_dff_bank_arbiter;
  localparam int W = 4;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  dff_bank_arbiter_if #(.WIDTH(W), .N_REQ(N)) bus ();
  dff_bank_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
    .input_clock1_1(clk),
    .input_reset1_2(rst),
    .bus(bus)
  );
  // reference: cycles left in the current transaction (2 = grant, 1 = ack, 0 = idle)
  int m_left = 0;
  int m_owner = 0;
  int m_ptr = N - 1;
  int m_q = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int winner(input logic [N-1:0] rq);
    for (int o = 1; o <= N; o++)
      if (rq[(m_ptr + o) % N]) return (m_ptr + o) % N;
    return -1;
  endfunction
  task automatic model_edge(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] d, input logic f);
    if (r) begin
      m_left = 0; m_q = 0; m_owner = 0; m_ptr = N - 1;
    end else if (m_left == 2) begin
      m_q = int'(d[m_owner*W +: W]); m_left = 1;
    end else if (m_left == 1) begin
      m_ptr = m_owner; m_left = 0;
    end else if (!f && rq != '0) begin
      m_owner = winner(rq); m_left = 2;
    end
  endtask
  task automatic compare_all();
    logic [N-1:0] onehot;
    onehot = N'(1) << m_owner;
    check("grant", 32'(bus.output_grant), (m_left == 2) ? 32'(onehot) : 32'd0);
    check("ack",   32'(bus.output_ack),   (m_left == 1) ? 32'(onehot) : 32'd0);
    check("busy",  32'(bus.output_busy), 32'(m_left != 0));
    check("owner", 32'(bus.output_owner), 32'(m_owner));
    check("q",     32'(bus.output_q), 32'(m_q));
    check("qn",    32'(bus.output_qn), 32'((~m_q) & ((1 << W) - 1)));
  endtask
  task automatic cyc(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] d, input logic f);
    rst = r;
    bus.input_req = rq;
    bus.input_data = d;
    bus.input_freeze = f;
    model_edge(r, rq, d, f);
    @(negedge clk);
    compare_all();
  endtask
  initial begin
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int exp_q[5] = '{1, 2, 3, 4, 1};
    int qs[$];
    cyc(1, '0, '0, 0);
    cyc(1, '0, '0, 0);
    check("rst_q", 32'(bus.output_q), 32'h0);
    check("rst_qn", 32'(bus.output_qn), 32'hF);
    check("rst_busy", 32'(bus.output_busy), 32'h0);
    cyc(0, 4'b0001, 16'h000A, 0);
    check("sw_grant", 32'(bus.output_grant), 32'h1);
    cyc(0, 4'b0000, 16'h000A, 0);
    check("sw_ack", 32'(bus.output_ack), 32'h1);
    check("sw_q", 32'(bus.output_q), 32'hA);
    check("sw_qn", 32'(bus.output_qn), 32'h5);
    cyc(0, 4'b0000, 16'h000A, 0);
    check("sw_busy_end", 32'(bus.output_busy), 32'h0);
    cyc(1, '0, '0, 0);
    for (int i = 0; i < 15; i++) begin
      cyc(0, 4'b1111, 16'h4321, 0);
      if (bus.output_grant != '0) order.push_back(int'(bus.output_owner));
      if (bus.output_ack != '0) qs.push_back(int'(bus.output_q));
    end
    check("rr_count", 32'(order.size()), 32'd5);
    check("rr_qcount", 32'(qs.size()), 32'd5);
    for (int i = 0; i < 5 && i < order.size() && i < qs.size(); i++) begin
      check($sformatf("rr_owner%0d", i), 32'(order[i]), 32'(exp_order[i]));
      check($sformatf("rr_q%0d", i), 32'(qs[i]), 32'(exp_q[i]));
    end
    for (int i = 0; i < 5; i++) begin
      cyc(0, 4'b0100, 16'h4321, 1);
      check("frz_grant", 32'(bus.output_grant), 32'h0);
      check("frz_q", 32'(bus.output_q), 32'h1);
    end
    cyc(0, 4'b0100, 16'h4321, 0);
    check("unfrz_grant", 32'(bus.output_grant), 32'h4);
    cyc(0, 4'b0100, 16'h4321, 1);
    check("frz_mid_ack", 32'(bus.output_ack), 32'h4);
    check("frz_mid_q", 32'(bus.output_q), 32'h3);
    cyc(0, 4'b0000, 16'h4321, 1);
    cyc(0, 4'b0010, 16'h0070, 0);
    check("rmid_grant", 32'(bus.output_grant), 32'h2);
    cyc(1, 4'b0010, 16'h0070, 0);
    check("rmid_q", 32'(bus.output_q), 32'h0);
    check("rmid_ack", 32'(bus.output_ack), 32'h0);
    check("rmid_busy", 32'(bus.output_busy), 32'h0);
    cyc(0, 4'b0010, 16'h0070, 0);
    check("rmid_regrant", 32'(bus.output_grant), 32'h2);
    cyc(0, 4'b0000, 16'h0070, 0);
    check("rmid_q2", 32'(bus.output_q), 32'h7);
    cyc(0, 4'b0000, 16'h0070, 0);
    cyc(0, 4'b0100, 16'h0900, 0);
    check("drop_grant", 32'(bus.output_grant), 32'h4);
    cyc(0, 4'b0000, 16'h0900, 0);
    check("drop_ack", 32'(bus.output_ack), 32'h4);
    check("drop_q", 32'(bus.output_q), 32'h9);
    cyc(0, 4'b0000, 16'h0900, 0);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 49) == 0, N'($urandom), (N*W)'($urandom),
          $urandom_range(0, 3) == 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/dff_bank_arbiter.md
# dff_bank_arbiter

Round-robin controller that shares one WIDTH-bit D flip-flop register bank among N_REQ requesters. Each granted request performs exactly one synchronous write of that requester's data word into the bank. The bank drives complementary Q / ~Q outputs, matching the generated D flip-flop cells it replaces. It sits between requester logic and the shared storage/LED outputs.

## Interface
- WIDTH, 4, data width of the shared register bank (1..16)
- N_REQ, 4, number of requesters (2..8)
- OWNER_W, $clog2(N_REQ), width of the owner index (derived, not overridden)

- input_clock1_1  in  1  single clock; all state updates on rising edge
- input_reset1_2  in  1  synchronous, active-high reset
- input_req  in  N_REQ  request level per requester; bit i = requester i
- input_data  in  N_REQ*WIDTH  requester i's data word at bits [i*WIDTH +: WIDTH]
- input_freeze  in  1  when high, no new grant is issued; any in-flight transaction completes
- output_grant  out  N_REQ  one-hot grant, high during the GRANT state only
- output_ack  out  N_REQ  one-hot, one-cycle pulse in the ACK state
- output_owner  out  OWNER_W  index of the last granted requester
- output_busy  out  1  high in GRANT and ACK
- output_q  out  WIDTH  shared register contents
- output_qn  out  WIDTH  bitwise complement of output_q, always

## Operation
- States: IDLE, GRANT, ACK.
- IDLE
  - If input_freeze=0 and input_req≠0, select the first requester with req set, searching ptr+1, ptr+2, … mod N_REQ.
  - Latch the selected index into owner and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT
  - output_grant[owner]=1.
  - At the closing edge, output_q ← input_data slice of owner. The sample is taken at that edge.
  - The write is committed even if input_req[owner] drops during GRANT.
  - Go to ACK.
- ACK
  - output_ack[owner]=1. output_q already shows the new value.
  - ptr ← owner. Go to IDLE.
- Round-robin pointer ptr
  - OWNER_W bits, internal.
  - The requester just served gets lowest priority next time.
  - When ptr advances past N_REQ-1 it wraps to 0.
- input_freeze
  - Sampled only in IDLE.
  - Asserting it in GRANT or ACK does not abort the transaction.
- Requests are levels. A requester still holding req after its ACK competes normally and cannot win while others are requesting.
- output_qn is combinational ~output_q. No separate state.
- output_q changes only at the GRANT→ACK edge or on reset.

## Timing
- Reset values (edge with input_reset1_2=1):
  - state=IDLE, output_q=0, output_qn=all ones
  - output_grant=0, output_ack=0, output_busy=0, output_owner=0
  - ptr=N_REQ-1, so requester 0 has top priority first
- Reset has priority over every other event. A reset on the GRANT→ACK edge suppresses the write: q becomes 0, not the data.
- Latency:
  - req seen in IDLE at edge k → grant high in cycle k+1
  - q updated and ack high in cycle k+2
  - back to IDLE at k+3
- Throughput: one write per 3 cycles under continuous requests. The next grant can start the cycle after ACK's closing edge.
- No combinational path from input_req to output_grant. All outputs except output_qn are registered.
- Simultaneous events:
  - Multiple reqs in IDLE: round-robin selects one.
  - New reqs arriving during GRANT or ACK wait for IDLE.
  - Freeze and req rising together in IDLE: no grant.

## Test plan
- Reset behaviour: with N_REQ=4, WIDTH=4, assert reset 2 cycles → q=0x0, qn=0xF, grant=0, ack=0, busy=0, owner=0.
- Single write: req=0001 with data0=0xA held for 1 cycle in IDLE → grant=0001 next cycle; following cycle ack=0001, q=0xA, qn=0x5; busy high for exactly 2 cycles.
- Round-robin and wrap: req=1111 held continuously, dataN=N+1 → grants in order 0,1,2,3,0; q sequence 1,2,3,4,1; owner wraps 3→0.
- Freeze: req=0100 with freeze=1 for 5 cycles → no grant, q unchanged. Drop freeze → grant=0100 one cycle later. Assert freeze during GRANT → write and ack still complete.
- Reset mid-transaction: req=0010, data1=0x7; reset coincides with the GRANT→ACK edge → q stays 0, no ack pulse, state IDLE. The next grant goes to requester 1 (ptr reset to 3, so it wins if it is the only requester).
- Req drop: requester 2 deasserts req during its GRANT cycle → write of data2 still occurs and ack=0100 pulses.
